fir_interp_polyphase: RTL and testbench
=======================================

Name: fir_interp_polyphase

Overview:
- Polyphase interpolate-by-L FIR (synthesis side of the multirate filterbank); consumes one input sample per L output samples.
- Time-multiplexes a single 16s x 12s signed multiplier (28-bit product) with a registered accumulator, one MAC per cycle.
- Valid/ready stream handshake on both sides.
- Runtime-loadable coefficient register file; sits between the subband processing and the DAC-side output stream.

Parameters:
DATA_W, 16, input/output sample width (signed two's complement)
COEF_W, 12, coefficient width (signed, Q1.11 at default OUT_SHIFT)
ACC_W, 32, accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS_PER_PHASE)
L, 2, interpolation factor (number of phases), >= 2
TAPS_PER_PHASE, 8, taps per polyphase branch; total taps N = L*TAPS_PER_PHASE
OUT_SHIFT, 11, right shift applied to accumulator before saturation

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst  in  1  synchronous active-high reset
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(N)  coefficient index n (0..N-1)
coef_data  in  COEF_W  coefficient value h[n]
in_tdata  in  DATA_W  input sample
in_tvalid  in  1  input valid
in_tready  out  1  input ready
out_tdata  out  DATA_W  interpolated output sample
out_tvalid  out  1  output valid
out_tready  in  1  downstream ready

Behaviour:
- Reset (ap_rst=1 at a rising edge):
  - state=IDLE, phase=0, k=0, acc=0.
  - Delay line x[0..P-1]=0; all h[n]=0.
  - out_tvalid=0, out_tdata=0, in_tready=1 from the first cycle after reset.
  - Reset mid-operation aborts the current sample; no partial output is emitted.
- Coefficient write:
  - h[coef_addr] <= coef_data when coef_we=1 and state=IDLE.
  - Ignored in other states and ignored for coef_addr >= N.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_tready=1.
  - On in_tvalid&&in_tready: shift x[k] <= x[k-1], x[0] <= in_tdata; acc <= 0, phase <= 0, k <= 0; go to MAC.
- MAC (in_tready=0):
  - Each cycle: acc <= acc + sext(x[k]*h[k*L+phase]). The product is a full-precision 28-bit signed value, sign-extended to ACC_W.
  - k increments each cycle; after k=P-1, go to OUT. Exactly P cycles.
- OUT (in_tready=0):
  - On entry, out_tdata is registered as sat(( acc + 2^(OUT_SHIFT-1) ) >>> OUT_SHIFT): arithmetic shift, round half up.
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The rounding add is done at ACC_W+1 bits, so no internal wrap.
  - out_tvalid=1. out_tdata is held stable while out_tvalid && !out_tready.
- On out_tvalid&&out_tready:
  - If phase<L-1: phase++, acc<=0, k<=0, go to MAC.
  - Otherwise: out_tvalid<=0, go to IDLE.
- Latency: input accepted at edge t, first output valid at edge t+P+1.
- Throughput with out_tready held 1: one input per L*(P+1)+1 cycles.
- Outputs follow phase order 0..L-1 per input sample, so output sample m of input j corresponds to y[j*L+m].
- No combinational path from in_tvalid to in_tready or from out_tready to out_tvalid.
- in_tdata is don't-care when in_tvalid=0; no X-propagation into the delay line.

Test Plan:
- Impulse, unity scaling: h[0]=1024, h[1]=512, others 0; inputs 1000,0,0 -> outputs 500,250,0,0,0,0. First out_tvalid arrives 9 cycles after input accept.
- Full response order: h[n]=n+1, OUT_SHIFT=0 build, single input 1 then zeros -> outputs read 1,2,3,...,16 across 8 input samples (phase 0 then phase 1 each).
- Saturation: h[2k]=2047 for all k, eight inputs of 32767 -> phase-0 output 32767. Same with -32768 and h[2k]=2047 -> -32768.
- Rounding: h[0]=1, x=1024 -> out 1; x=1023 -> 0; x=-1024 -> 0; x=-1025 -> -1.
- Backpressure: hold out_tready=0 for 5 cycles in OUT -> out_tdata/out_tvalid stable, in_tready=0. Release -> next phase starts the following cycle, no sample lost or duplicated.
- Control corner cases:
  - coef_we pulse during MAC does not change h.
  - ap_rst asserted mid-MAC -> next cycle out_tvalid=0, in_tready=1; a subsequent impulse yields output 0 until coefficients are reloaded.

Source files
------------

// File: rtl/fir_interp_polyphase_if.sv
// rtl/fir_interp_polyphase_if.sv - stream and coefficient-write bundle for fir_interp_polyphase
// master: upstream/control side (drives coef_*, in_tdata/in_tvalid, out_tready)
// slave : the filter (drives in_tready, out_tdata/out_tvalid)
interface fir_interp_polyphase_if #(
    parameter int DATA_W         = 16,
    parameter int COEF_W         = 12,
    parameter int L              = 2,
    parameter int TAPS_PER_PHASE = 8
);
    localparam int AW = $clog2(L * TAPS_PER_PHASE);

    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic [DATA_W-1:0] in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [DATA_W-1:0] out_tdata;
    logic              out_tvalid;
    logic              out_tready;

    modport master (
        output coef_we, coef_addr, coef_data,
        output in_tdata, in_tvalid,
        input  in_tready,
        input  out_tdata, out_tvalid,
        output out_tready
    );

    modport slave (
        input  coef_we, coef_addr, coef_data,
        input  in_tdata, in_tvalid,
        output in_tready,
        output out_tdata, out_tvalid,
        input  out_tready
    );
endinterface

// File: rtl/fir_interp_polyphase.sv
// rtl/fir_interp_polyphase.sv - polyphase interpolate-by-L FIR, one shared MAC per cycle
// ap_clk : clock, rising edge
// ap_rst : synchronous active-high reset
// s      : slave side of fir_interp_polyphase_if (coef write port, input and output streams)
module fir_interp_polyphase #(
    parameter int DATA_W         = 16,
    parameter int COEF_W         = 12,
    parameter int ACC_W          = 32,
    parameter int L              = 2,
    parameter int TAPS_PER_PHASE = 8,
    parameter int OUT_SHIFT      = 11
) (
    input  logic ap_clk,
    input  logic ap_rst,
    fir_interp_polyphase_if.slave s
);
    localparam int P   = TAPS_PER_PHASE;
    localparam int N   = L * P;
    localparam int AW  = $clog2(N);
    localparam int KW  = (P > 1) ? $clog2(P) : 1;
    localparam int PHW = $clog2(L);
    localparam int PRW = DATA_W + COEF_W;

    // Rounding and saturation are done one bit wider than the accumulator
    // so that the half-LSB add can never wrap.
    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(((ACC_W+1)'(1) << OUT_SHIFT) >> 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state;
    logic [PHW-1:0]            phase;
    logic [KW-1:0]             k;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  x [P];
    logic signed [COEF_W-1:0]  h [N];
    logic                      in_tready_r;
    logic                      out_tvalid_r;
    logic [DATA_W-1:0]         out_tdata_r;

    logic [AW-1:0]             hidx;
    logic signed [PRW-1:0]     prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W:0]     rnd;
    logic signed [ACC_W:0]     shifted;
    logic [DATA_W-1:0]         sat_val;

    assign s.in_tready  = in_tready_r;
    assign s.out_tvalid = out_tvalid_r;
    assign s.out_tdata  = out_tdata_r;

    always_comb begin
        hidx    = AW'(k) * AW'(L) + AW'(phase);
        prod    = PRW'(x[k]) * PRW'(h[hidx]);
        acc_sum = acc + {{(ACC_W-PRW){prod[PRW-1]}}, prod};
        // The output is formed from the sum that includes the last tap, so it
        // can be registered on the same edge that leaves MAC.
        rnd     = $signed({acc_sum[ACC_W-1], acc_sum}) + RND;
        shifted = rnd >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state        <= IDLE;
            phase        <= '0;
            k            <= '0;
            acc          <= '0;
            in_tready_r  <= 1'b1;
            out_tvalid_r <= 1'b0;
            out_tdata_r  <= '0;
            for (int i = 0; i < P; i++) x[i] <= '0;
            for (int i = 0; i < N; i++) h[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s.coef_we && (int'(s.coef_addr) < N)) begin
                        h[s.coef_addr] <= s.coef_data;
                    end
                    if (s.in_tvalid) begin
                        for (int i = P - 1; i > 0; i--) x[i] <= x[i-1];
                        x[0]        <= s.in_tdata;
                        acc         <= '0;
                        phase       <= '0;
                        k           <= '0;
                        in_tready_r <= 1'b0;
                        state       <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (k == KW'(P - 1)) begin
                        out_tdata_r  <= sat_val;
                        out_tvalid_r <= 1'b1;
                        state        <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (s.out_tready) begin
                        out_tvalid_r <= 1'b0;
                        if (phase != PHW'(L - 1)) begin
                            phase <= phase + 1'b1;
                            acc   <= '0;
                            k     <= '0;
                            state <= MAC;
                        end else begin
                            in_tready_r <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_interp_polyphase.sv
// tb/tb_fir_interp_polyphase.sv - self-checking bench for fir_interp_polyphase against a convolution model
module tb_fir_interp_polyphase;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 12;
    localparam int ACC_W     = 32;
    localparam int L         = 2;
    localparam int P         = 8;
    localparam int N         = L * P;
    localparam int OUT_SHIFT = 11;

    logic clk = 1'b0;
    logic ap_rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    int   h_model [N];
    int   hist [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_interp_polyphase_if #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .L(L), .TAPS_PER_PHASE(P)
    ) bus ();

    fir_interp_polyphase #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
        .L(L), .TAPS_PER_PHASE(P), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .ap_clk(clk),
        .ap_rst(ap_rst),
        .s(bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // y[j*L+m] = sum_k h[k*L+m] * x[j-k], then round half up and clamp.
    function automatic longint ref_out(input int m);
        longint sum = 0;
        longint r;
        for (int kk = 0; kk < P; kk++) begin
            longint xv = (kk < hist.size()) ? longint'(hist[kk]) : 0;
            sum += longint'(h_model[kk*L + m]) * xv;
        end
        r = (sum + ((longint'(1) << OUT_SHIFT) / 2)) >>> OUT_SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < N; i++) h_model[i] = 0;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        bus.in_tvalid  = 1'b0;
        bus.coef_we    = 1'b0;
        bus.out_tready = 1'b1;
        repeat (2) @(negedge clk);
        ap_rst = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int addr, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr[3:0];
        bus.coef_data = val[COEF_W-1:0];
        @(negedge clk);
        bus.coef_we = 1'b0;
        h_model[addr] = val;
    endtask

    // Called and returns at a negedge. stall0 holds off phase 0 for that many cycles.
    task automatic send_sample(input int v, input int stall0, input bit rand_bp, input bit poke);
        int     to = 0;
        int     lat;
        int     n;
        longint exp_v;
        while (!bus.in_tready && to < 100) begin
            @(negedge clk);
            to++;
        end
        if (!bus.in_tready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        bus.in_tvalid = 1'b1;
        bus.in_tdata  = v[DATA_W-1:0];
        @(posedge clk);
        hist.push_front(v);
        if (hist.size() > P) void'(hist.pop_back());
        @(negedge clk);
        acc_cyc = cyc;
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = DATA_W'($urandom);
        lat = 1;
        if (poke) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = '0;
            bus.coef_data = 12'd555;
            @(negedge clk);
            bus.coef_we = 1'b0;
            lat++;
        end
        for (int m = 0; m < L; m++) begin
            while (!bus.out_tvalid && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            check("latency", lat, P + 1);
            if (!bus.out_tvalid) return;
            exp_v = ref_out(m);
            check("data", longint'($signed(bus.out_tdata)), exp_v);
            n = (m == 0) ? stall0 : 0;
            if (rand_bp) n = $urandom_range(0, 3);
            if (n > 0) begin
                bus.out_tready = 1'b0;
                repeat (n) begin
                    @(negedge clk);
                    check("hold_valid", bus.out_tvalid, 1);
                    check("hold_data", longint'($signed(bus.out_tdata)), exp_v);
                    check("hold_in_tready", bus.in_tready, 0);
                end
                bus.out_tready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            lat = 1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int a1;
        bus.coef_addr  = '0;
        bus.coef_data  = '0;
        bus.in_tdata   = '0;
        @(negedge clk);
        do_reset();

        // reset state
        check("rst_out_tvalid", bus.out_tvalid, 0);
        check("rst_out_tdata", bus.out_tdata, 0);
        check("rst_in_tready", bus.in_tready, 1);

        // impulse with unity-ish scaling, plus throughput between back-to-back inputs
        write_coef(0, 1024);
        write_coef(1, 512);
        send_sample(1000, 0, 0, 0);
        check("impulse_p1_model", ref_out(1), 250);
        a1 = acc_cyc;
        send_sample(0, 0, 0, 0);
        check("period", acc_cyc - a1, L * (P + 1) + 1);
        send_sample(0, 0, 0, 0);

        // full response order: 32 * (n+1)*64 >> 11 = n+1
        do_reset();
        for (int i = 0; i < N; i++) write_coef(i, (i + 1) * 64);
        send_sample(32, 0, 0, 0);
        for (int i = 0; i < P - 1; i++) send_sample(0, 0, 0, 0);

        // saturation both ways
        do_reset();
        for (int i = 0; i < P; i++) write_coef(2 * i, 2047);
        for (int i = 0; i < P; i++) send_sample(32767, 0, 0, 0);
        check("sat_pos_model", ref_out(0), 32767);
        for (int i = 0; i < P; i++) send_sample(-32768, 0, 0, 0);
        check("sat_neg_model", ref_out(0), -32768);

        // rounding at the half-LSB boundary
        do_reset();
        write_coef(0, 1);
        send_sample(1024, 0, 0, 0);
        send_sample(1023, 0, 0, 0);
        send_sample(-1024, 0, 0, 0);
        send_sample(-1025, 0, 0, 0);

        // backpressure on phase 0, coef write attempt during MAC
        write_coef(0, 1024);
        write_coef(1, -700);
        send_sample(12345, 5, 0, 0);
        send_sample(-2222, 0, 0, 1);
        send_sample(1000, 0, 0, 0);

        // reset in the middle of MAC
        bus.in_tvalid = 1'b1;
        bus.in_tdata  = 16'd3000;
        @(negedge clk);
        bus.in_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        ap_rst = 1'b1;
        @(negedge clk);
        ap_rst = 1'b0;
        model_clear();
        check("midrst_out_tvalid", bus.out_tvalid, 0);
        check("midrst_in_tready", bus.in_tready, 1);
        send_sample(1000, 0, 0, 0);

        // randomized coefficients, samples and backpressure
        for (int i = 0; i < N; i++) write_coef(i, int'($urandom_range(0, 4095)) - 2048);
        for (int i = 0; i < 24; i++) send_sample(int'($urandom_range(0, 65535)) - 32768, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
